// File: rtl/adc_capture_stream.sv
// adc_capture_stream
//   Captures a parallel ADC bus plus its out-of-range flag, optionally block-averages
//   2^L samples per output word, buffers results in a first-word-fall-through FIFO and
//   presents them on a valid/ready stream. Everything runs on the ADC clock.
//
// Ports
//   ADC_CLK     sole clock (rising edge), same clock as driven to the ADC
//   RST         synchronous active-high reset
//   EN          capture enable
//   AVG_LOG2    averaging exponent L (0 = raw), latched when capture starts
//   CLR_STATUS  single-cycle pulse clearing OVERFLOW and DROP_CNT
//   ADC_D       ADC data bus
//   ADC_DTR     ADC out-of-range flag, aligned with ADC_D
//   OUT_DATA    FIFO head data (averaged or raw)
//   OUT_OOR     OR of ADC_DTR over the samples forming OUT_DATA
//   OUT_VALID   FIFO not empty
//   OUT_READY   downstream accepts the head word
//   OVERFLOW    sticky, a result was dropped on a full FIFO
//   DROP_CNT    saturating count of dropped results
//   FILL        current FIFO occupancy
module adc_capture_stream #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned MAX_AVG_LOG2 = 4,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned LW          = $clog2(MAX_AVG_LOG2 + 1),
  localparam int unsigned FW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              ADC_CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [LW-1:0]     AVG_LOG2,
  input  logic              CLR_STATUS,
  input  logic [DATA_W-1:0] ADC_D,
  input  logic              ADC_DTR,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_OOR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OVERFLOW,
  output logic [15:0]       DROP_CNT,
  output logic [FW-1:0]     FILL
);

  localparam int unsigned ACC_W = DATA_W + MAX_AVG_LOG2;
  localparam int unsigned CNT_W = MAX_AVG_LOG2;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Input stage
  logic [DATA_W-1:0] adc_d_q;
  logic              adc_dtr_q;

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      adc_d_q   <= '0;
      adc_dtr_q <= 1'b0;
    end else begin
      adc_d_q   <= ADC_D;
      adc_dtr_q <= ADC_DTR;
    end
  end

  // Window engine
  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              oor_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LW-1:0]     l_q;

  logic [LW-1:0]     l_clamp;
  logic [CNT_W-1:0]  last_cnt;
  logic              win_last;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0] res_data;
  logic              res_oor;
  logic              wr_req;
  logic              unused_shift_bits;

  always_comb begin
    l_clamp  = (AVG_LOG2 > LW'(MAX_AVG_LOG2)) ? LW'(MAX_AVG_LOG2) : AVG_LOG2;
    last_cnt = CNT_W'((32'd1 << l_q) - 32'd1);
    win_last = (cnt_q == last_cnt);
    // The sample consumed this cycle is folded in before the shift.
    sum      = acc_q + ACC_W'(adc_d_q);
    shifted  = sum >> l_q;
    res_data = shifted[DATA_W-1:0];
    res_oor  = oor_q | adc_dtr_q;
    // EN low in RUN aborts the window, even on its final sample.
    wr_req   = (state_q == StRun) && EN && win_last;
  end

  assign unused_shift_bits = ^shifted[ACC_W-1:DATA_W];

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state_q <= StIdle;
      acc_q   <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      l_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (EN) begin
            state_q <= StRun;
            l_q     <= l_clamp;
            acc_q   <= '0;
            oor_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (!EN) begin
            state_q <= StIdle;
          end else if (win_last) begin
            // Back-to-back windows: restart in the same cycle as the write.
            acc_q <= '0;
            oor_q <= 1'b0;
            cnt_q <= '0;
          end else begin
            acc_q <= sum;
            oor_q <= res_oor;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FWFT FIFO of {oor, data}
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [FW-1:0]   fill_q;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full  = (fill_q == FW'(FIFO_DEPTH));
    empty = (fill_q == '0);
    pop   = !empty && OUT_READY;
    // A pop frees the slot the write lands in, so full plus pop still accepts.
    push  = wr_req && (!full || pop);
    drop  = wr_req && full && !pop;
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {res_oor, res_data};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Status
  logic        overflow_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      // A drop coinciding with a clear counts as the first drop after it.
      overflow_q <= 1'b1;
      if (CLR_STATUS) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (CLR_STATUS) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign OUT_DATA  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign OUT_OOR   = mem_q[rd_ptr_q][DATA_W];
  assign OUT_VALID = !empty;
  assign OVERFLOW  = overflow_q;
  assign DROP_CNT  = drop_cnt_q;
  assign FILL      = fill_q;

endmodule
